// File: rtl/aes_block_gather_pkg.sv
// Shared constants for the AES input datapath (gather, byte-order, cipher stages).
package aes_block_gather_pkg;

    localparam int NB     = 128;
    localparam int BYTE   = 8;
    localparam int NBYTES = NB / BYTE;
    localparam int CNT_W  = 4;

    // The assembly register keeps every byte but the last; the last one
    // goes straight from in_byte into the holding register.
    localparam int ASM_W = NB - BYTE;

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NBYTES - 1);

    typedef logic [NB-1:0]   block_t;
    typedef logic [BYTE-1:0] byte_t;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/aes_block_gather_if.sv
// Byte-in / block-out handshake bundle of the AES block gatherer.
interface aes_block_gather_if;
    import aes_block_gather_pkg::*;

    byte_t  in_byte;
    logic   in_valid;
    logic   in_ready;
    logic   clear;
    block_t out_block;
    logic   out_valid;
    logic   out_ready;
    cnt_t   byte_cnt;

    // master: upstream byte source plus downstream consumer.
    modport master (
        output in_byte, in_valid, clear, out_ready,
        input  in_ready, out_block, out_valid, byte_cnt
    );

    // slave: the gatherer itself.
    modport slave (
        input  in_byte, in_valid, clear, out_ready,
        output in_ready, out_block, out_valid, byte_cnt
    );

endinterface

// File: rtl/aes_block_gather.sv
// Packs 16 input bytes (first byte most significant) into one 128-bit block,
// with a single holding register so the next block can fill while this one waits.
module aes_block_gather
    import aes_block_gather_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    aes_block_gather_if.slave bus
);

    cnt_t             cnt_q;
    logic [ASM_W-1:0] asm_w;
    block_t           block_q;
    logic             valid_q;

    logic last_slot;
    logic in_ready;
    logic accept;
    logic complete;
    logic xfer;

    assign last_slot = (cnt_q == LAST_SLOT);

    // NOTE: in_ready is built from registered state and clear only, so no
    // combinational path runs from out_ready back to the upstream source.
    assign in_ready = !bus.clear && !(last_slot && valid_q);
    assign accept   = bus.in_valid && in_ready;
    assign complete = accept && last_slot;
    assign xfer     = valid_q && bus.out_ready;

    // Each slot owns its own register; slot k sits at the k-th byte from the top.
    for (genvar g = 0; g < NBYTES - 1; g++) begin : g_slot
        byte_t slot_q;

        // NOTE: the slots are reset too, so a dropped block can never leak
        // stale bytes into a later one, even through a don't-care path.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_q <= '0;
            end else if (accept && (cnt_q == CNT_W'(g))) begin
                slot_q <= bus.in_byte;
            end
        end

        assign asm_w[ASM_W-1-BYTE*g -: BYTE] = slot_q;
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.clear) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= last_slot ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // A completing accept and an output transfer are mutually exclusive,
    // because in_ready is low whenever both could be requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block_q <= '0;
            valid_q <= 1'b0;
        end else if (complete) begin
            block_q <= {asm_w, bus.in_byte};
            valid_q <= 1'b1;
        end else if (xfer) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_block = block_q;
    assign bus.out_valid = valid_q;
    assign bus.byte_cnt  = cnt_q;

endmodule

// File: tb/tb_aes_block_gather.sv
// Self-checking bench for aes_block_gather: vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_aes_block_gather;
    import aes_block_gather_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    aes_block_gather_if bus();

    aes_block_gather dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: bytes of the block being assembled, plus the held block.
    logic [7:0] mq[$];
    block_t     m_block;
    logic       m_valid;
    logic       last_rdy;

    typedef struct {
        logic       v;
        logic [7:0] b;
        logic       c;
        logic       r;
        logic       exp_rdy;
        logic [3:0] exp_cnt;
        logic       exp_ov;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic block_t reverse_bytes(input block_t blk);
        block_t rev;
        for (int i = 0; i < NBYTES; i++) rev[8*i +: 8] = blk[NB-1-8*i -: 8];
        return rev;
    endfunction

    // One clock: drive inputs, check in_ready, advance model, check outputs.
    // Entered and left 1 time unit after a rising edge.
    task automatic cyc(input logic v, input logic [7:0] b, input logic c, input logic r);
        logic rdy;
        logic xfer;
        logic done;
        bus.in_valid  = v;
        bus.in_byte   = b;
        bus.clear     = c;
        bus.out_ready = r;
        rdy = !c && !(mq.size() == NBYTES - 1 && m_valid);
        #1;
        last_rdy = bus.in_ready;
        check("in_ready", bus.in_ready, rdy);
        @(posedge clk);
        xfer = m_valid && r;
        done = 1'b0;
        if (c) begin
            mq.delete();
        end else if (v && rdy) begin
            mq.push_back(b);
            if (mq.size() == NBYTES) begin
                m_block = '0;
                foreach (mq[i]) m_block = {m_block[NB-9:0], mq[i]};
                m_valid = 1'b1;
                done    = 1'b1;
                mq.delete();
            end
        end
        if (xfer && !done) m_valid = 1'b0;
        #1;
        check("out_valid", bus.out_valid, m_valid);
        check("byte_cnt", bus.byte_cnt, mq.size());
        check("out_block", bus.out_block, m_block);
    endtask

    task automatic model_reset();
        mq.delete();
        m_block = '0;
        m_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
        tbl[1] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
        tbl[2] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0};
        tbl[3] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0};
        tbl[4] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0};
        tbl[5] = '{1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
        tbl[6] = '{1'b0, 8'hCC, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};
        tbl[7] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
        tbl[8] = '{1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
        tbl[9] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};

        // Power-on reset.
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_byte   = '0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        #3;
        check("reset out_valid", bus.out_valid, 1'b0);
        check("reset out_block", bus.out_block, '0);
        check("reset byte_cnt", bus.byte_cnt, 4'd0);
        check("reset in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Vector table: partial fills, gaps and clear pulses.
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].v, tbl[i].b, tbl[i].c, tbl[i].r);
            check($sformatf("tbl%0d in_ready", i), last_rdy, tbl[i].exp_rdy);
            check($sformatf("tbl%0d byte_cnt", i), bus.byte_cnt, tbl[i].exp_cnt);
            check($sformatf("tbl%0d out_valid", i), bus.out_valid, tbl[i].exp_ov);
        end

        // Back-to-back stream with the consumer always ready.
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b1);
        check("stream out_valid", bus.out_valid, 1'b1);
        check("stream block", bus.out_block, 128'h000102030405060708090A0B0C0D0E0F);
        check("stream reversed", reverse_bytes(bus.out_block), 128'h0F0E0D0C0B0A09080706050403020100);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("stream drained", bus.out_valid, 1'b0);

        // Clear discards the partial block; the next block is exact.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'hAA, 1'b0, 1'b1);
        cyc(1'b1, 8'hBB, 1'b1, 1'b1);
        check("clear no accept", last_rdy, 1'b0);
        check("clear byte_cnt", bus.byte_cnt, 4'd0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        check("clear block", bus.out_block, 128'h202122232425262728292A2B2C2D2E2F);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure: two blocks with the consumer stalled.
        for (int i = 0; i < 31; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 8'h1F, 1'b0, 1'b0);
            check("bp in_ready low", last_rdy, 1'b0);
            check("bp byte_cnt", bus.byte_cnt, 4'd15);
            check("bp held block", bus.out_block, 128'h000102030405060708090A0B0C0D0E0F);
        end
        cyc(1'b1, 8'h1F, 1'b0, 1'b1);
        check("bp xfer in_ready", last_rdy, 1'b0);
        check("bp xfer out_valid", bus.out_valid, 1'b0);
        cyc(1'b1, 8'h1F, 1'b0, 1'b0);
        check("bp accept", last_rdy, 1'b1);
        check("bp second valid", bus.out_valid, 1'b1);
        check("bp second block", bus.out_block, 128'h101112131415161718191A1B1C1D1E1F);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Random in_valid gaps must not alter block content.
        for (int i = 0; i < 16; i++) begin
            int gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) cyc(1'b0, 8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            if (i < 15) check("gap no early valid", bus.out_valid, 1'b0);
            cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        end
        check("gap block", bus.out_block, 128'h303132333435363738393A3B3C3D3E3F);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset with a held block and a partial one.
        for (int i = 0; i < 25; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("pre-reset byte_cnt", bus.byte_cnt, 4'd9);
        check("pre-reset out_valid", bus.out_valid, 1'b1);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async out_valid", bus.out_valid, 1'b0);
        check("async out_block", bus.out_block, '0);
        check("async byte_cnt", bus.byte_cnt, 4'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        check("post-reset block", bus.out_block, 128'h404142434445464748494A4B4C4D4E4F);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 31) == 0),
                1'($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
